exp_unit_scheduler: RTL and testbench
=====================================

// Module: exp_unit_scheduler
// PURPOSE
//  Round-robin scheduler sharing one exponent unit between NUM_REQ requesters in the
//  softmax_8_bit datapath. Latches a requester's 8-bit operand, sequences the unit's
//  enable/ack protocol (clear, run, capture), and returns the result on a per-requester pulse.
//  Sits between the softmax lane front-ends and the single exponent instance.
// PARAMETERS
//  DATA_WIDTH   8    operand/result width (unit's format)
//  NUM_REQ      4    number of requesters, 2..8
//  TIMEOUT_CYC  15   max RUN cycles waiting for exp_ack before abort (unit nominal: 7)
// PORTS
//  clk        in   1                   clock, rising edge
//  rst        in   1                   reset, asynchronous, active-high
//  req_valid  in   NUM_REQ             request per requester; hold until req_ready
//  req_x      in   NUM_REQ*DATA_WIDTH  operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready  out  NUM_REQ             one-hot 1-cycle pulse: request i accepted
//  rsp_valid  out  NUM_REQ             one-hot 1-cycle pulse: result for requester i
//  rsp_data   out  DATA_WIDTH          result, valid only with rsp_valid
//  rsp_err    out  1                   with rsp_valid: 1 = timed out, rsp_data = 0
//  exp_x      out  DATA_WIDTH          operand to unit (held constant through RUN)
//  exp_enable out  1                   unit enable; low = unit clears/reinitialises
//  exp_result in   DATA_WIDTH          unit output_exp
//  exp_ack    in   1                   unit ack
//  busy       out  1                   1 in any state but IDLE
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, rr pointer=0, all outputs 0, exp_enable=0.
//  FSM (registered outputs):
//   IDLE : exp_enable=0. If any req_valid: pick winner by round-robin starting at pointer;
//          latch req_x[winner] into exp_x, pulse req_ready[winner], -> CLEAR.
//   CLEAR: exp_enable=0 exactly 1 cycle (guarantees unit reinit between jobs) -> RUN.
//   RUN  : exp_enable=1; timeout counter increments each cycle.
//          exp_ack=1 -> capture exp_result, -> DONE.
//          counter reaches TIMEOUT_CYC with no ack -> -> DONE with err flag set.
//   DONE : pulse rsp_valid[owner], rsp_data=captured (0 on err), rsp_err=err;
//          exp_enable=0; pointer = owner+1 mod NUM_REQ; -> IDLE.
//  Latency (accept pulse to rsp pulse) with unit ack after A enabled cycles: A+2 cycles;
//  IDLE->new accept is back-to-back possible the cycle after DONE (min 1 IDLE cycle).
//  Arbitration: rotating priority; owner just served has lowest priority next round.
//   Single requester held high is served every job; no requester starves (bound: NUM_REQ jobs).
//  req_valid dropped before req_ready: request withdrawn, no response, not an error.
//  req_valid changes during CLEAR/RUN/DONE ignored; exp_x never changes mid-job.
//  exp_ack high in CLEAR/IDLE (stale from previous job) ignored.
//  Ack on exactly cycle TIMEOUT_CYC: ack wins, no error.
//  Reset mid-job: job dropped, no rsp pulse; requester must re-request.
//  Pointer wraps NUM_REQ-1 -> 0. At most one bit of req_ready / rsp_valid ever set.
// STRUCTURE
//  Shared package softmax_pkg: DATA_WIDTH, state encoding (IDLE/CLEAR/RUN/DONE),
//   EXP_NOMINAL_LAT=7, TIMEOUT default.
//  Sub-module rr_arbiter (NUM_REQ, req vector + pointer -> one-hot grant + index),
//   combinational, reusable by the softmax sum/divide stage.
//  Top: FSM, operand/result/owner registers, timeout counter ($clog2(TIMEOUT_CYC+1) bits).
// TESTING (bench pairs scheduler with real exponent unit and a stub unit with programmable ack)
//  1 single req0, x=8'h38 (1.0) -> req_ready=4'b0001, rsp_valid[0] 9 cycles later, err=0,
//    rsp_data equals standalone unit result for same x.
//  2 all four req_valid held -> service order 0,1,2,3,0; each accept 1 cycle after prior DONE.
//  3 stub never acks -> rsp_valid pulse after TIMEOUT_CYC RUN cycles, rsp_err=1, rsp_data=0;
//    next request then completes normally.
//  4 stub acks on cycle 15 exactly -> rsp_err=0, data captured.
//  5 rst asserted mid-RUN -> all outputs 0 same cycle (async), no rsp pulse, next job clean.
//  6 stub holds ack=1 across jobs; req1 then req2 -> each job shows 1-cycle exp_enable=0
//    before RUN; no premature capture; req withdrawn in IDLE gets no response.

Source files
------------

// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax_8_bit datapath: widths, exponent unit timing
// and the scheduler state encoding.
package softmax_pkg;

    localparam int DATA_WIDTH      = 8;
    localparam int EXP_NOMINAL_LAT = 7;
    localparam int TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the search starts at ptr_i and wraps,
// so the requester at ptr_i has the highest priority.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] pos;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        sum     = '0;
        pos     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                sum = sum - (IDX_W+1)'(NUM_REQ);
            end
            pos = sum[IDX_W-1:0];
            if (!any_o && req_i[pos]) begin
                any_o        = 1'b1;
                grant_o[pos] = 1'b1;
                idx_o        = pos;
            end
        end
    end

endmodule

// File: rtl/exp_unit_scheduler.sv
// Shares one exponent unit between NUM_REQ requesters: round-robin accept, one-cycle
// unit clear, run with ack timeout, then a one-hot response pulse to the owner.
module exp_unit_scheduler #(
    parameter int DATA_WIDTH  = softmax_pkg::DATA_WIDTH,
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = softmax_pkg::TIMEOUT_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_x,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic [DATA_WIDTH-1:0]         exp_x,
    output logic                          exp_enable,
    input  logic [DATA_WIDTH-1:0]         exp_result,
    input  logic                          exp_ack,
    output logic                          busy,
    output softmax_pkg::sched_state_e     state_dbg
);
    import softmax_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    // Handshake: a requester holds req_valid until it sees its req_ready pulse;
    // rsp_valid is a single-cycle pulse with no back-pressure.
    sched_state_e             state_q, state_d;
    logic [IDX_W-1:0]         ptr_q, ptr_d;
    logic [IDX_W-1:0]         owner_q, owner_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]         cnt_inc;
    logic [DATA_WIDTH-1:0]    exp_x_q, exp_x_d;
    logic                     exp_enable_q, exp_enable_d;
    logic [NUM_REQ-1:0]       req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]       rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]    rsp_data_q, rsp_data_d;
    logic                     rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0]       arb_grant;
    logic [IDX_W-1:0]         arb_idx;
    logic                     arb_any;
    logic [DATA_WIDTH-1:0]    req_x_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
        assign req_x_arr[g] = req_x[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        cnt_d        = cnt_q;
        exp_x_d      = exp_x_q;
        exp_enable_d = 1'b0;
        req_ready_d  = '0;
        rsp_valid_d  = '0;
        rsp_data_d   = '0;
        rsp_err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    owner_d     = arb_idx;
                    exp_x_d     = req_x_arr[arb_idx];
                    req_ready_d = arb_grant;
                    state_d     = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                cnt_d        = '0;
                exp_enable_d = 1'b1;
                state_d      = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_inc;
                // Ack is checked before the timeout so an ack on the last allowed cycle wins.
                if (exp_ack) begin
                    rsp_valid_d = NUM_REQ'(1) << owner_q;
                    rsp_data_d  = exp_result;
                    state_d     = ST_DONE;
                end else if (cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
                    rsp_valid_d = NUM_REQ'(1) << owner_q;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    exp_enable_d = 1'b1;
                end
            end
            ST_DONE: begin
                ptr_d   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            cnt_q        <= '0;
            exp_x_q      <= '0;
            exp_enable_q <= 1'b0;
            req_ready_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            exp_x_q      <= exp_x_d;
            exp_enable_q <= exp_enable_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign exp_x      = exp_x_q;
    assign exp_enable = exp_enable_q;
    assign busy       = (state_q != ST_IDLE);
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_exp_unit_scheduler.sv
// Bench for exp_unit_scheduler with a programmable-latency stub exponent unit and a
// job-timeline reference model checked every cycle.
module tb_exp_unit_scheduler;

    localparam int N    = 4;
    localparam int DW   = 8;
    localparam int TO   = 15;
    localparam int SB_W = 2 + 1 + DW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*DW-1:0]   req_x = '0;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err;
    logic [DW-1:0]     exp_x;
    logic              exp_enable;
    logic [DW-1:0]     exp_result;
    logic              exp_ack;
    logic              busy;
    softmax_pkg::sched_state_e state_dbg;

    exp_unit_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_x(req_x),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .exp_x(exp_x), .exp_enable(exp_enable),
        .exp_result(exp_result), .exp_ack(exp_ack), .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- stub exponent unit ----------------
    int stub_mode = 0;   // 0: ack after stub_lat enabled cycles, 1: never ack, 2: ack stuck high
    int stub_lat  = 7;
    int en_cnt;

    function automatic logic [DW-1:0] unit_fn(input logic [DW-1:0] x);
        return {x[3:0], x[7:4]} ^ 8'h5A;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) en_cnt <= 0;
        else     en_cnt <= exp_enable ? en_cnt + 1 : 0;
    end

    assign exp_ack    = (stub_mode == 2) ? 1'b1 : (stub_mode == 1) ? 1'b0 : (en_cnt >= stub_lat);
    assign exp_result = exp_ack ? unit_fn(exp_x) : 8'hEE;

    // ---------------- scoreboard bookkeeping ----------------
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // RUN cycles a job takes with the stub as currently configured, and whether it times out.
    function automatic int run_len();
        if (stub_mode == 2) return 1;
        if (stub_mode == 1) return TO;
        return (stub_lat + 1 > TO) ? TO : stub_lat + 1;
    endfunction

    function automatic bit run_err();
        return (stub_mode == 1) || (stub_mode == 0 && stub_lat + 1 > TO);
    endfunction

    // ---------------- reference model: one job timeline ----------------
    bit             m_active = 1'b0;
    int             m_acc, m_rsp, m_owner, m_ptr = 0;
    bit             m_err;
    logic [DW-1:0]  m_x;
    logic [SB_W-1:0] exp_q[$];

    // observations for the directed literal checks
    int             last_rdy_cyc, last_rsp_cyc, rsp_count = 0;
    logic [N-1:0]   last_rdy_vec;
    logic [DW-1:0]  last_rsp_data;
    logic           last_rsp_err;
    int             own_q[$];
    int             rdy_cyc_q[$];
    int             rsp_cyc_q[$];

    logic [N-1:0]   e_rdy, e_rsp;
    logic           e_busy, e_en;
    logic [SB_W-1:0] sb_word;
    int             w;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("rst_req_ready", 32'(req_ready), 32'(0));
            chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
            chk("rst_busy", 32'(busy), 32'(0));
            chk("rst_exp_enable", 32'(exp_enable), 32'(0));
            m_active = 1'b0;
            m_ptr    = 0;
            exp_q.delete();
        end else begin
            e_rdy  = (m_active && cyc == m_acc) ? N'(1 << m_owner) : '0;
            e_rsp  = (m_active && cyc == m_rsp) ? N'(1 << m_owner) : '0;
            e_busy = m_active && cyc >= m_acc && cyc <= m_rsp;
            e_en   = m_active && cyc >= m_acc + 1 && cyc <= m_rsp - 1;
            chk("req_ready", 32'(req_ready), 32'(e_rdy));
            chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("exp_enable", 32'(exp_enable), 32'(e_en));
            if (e_busy) chk("exp_x", 32'(exp_x), 32'(m_x));
            if (m_active && cyc == m_rsp && exp_q.size() > 0) begin
                sb_word = exp_q.pop_front();
                chk("rsp_word", 32'({2'(oh_idx(rsp_valid)), rsp_err, rsp_data}), 32'(sb_word));
            end
            if (!m_active || cyc > m_rsp) begin
                w = rr_pick(req_valid, m_ptr);
                if (w >= 0) begin
                    m_active = 1'b1;
                    m_owner  = w;
                    m_x      = req_x[w*DW +: DW];
                    m_acc    = cyc + 1;
                    m_rsp    = m_acc + run_len() + 1;
                    m_err    = run_err();
                    m_ptr    = (w + 1) % N;
                    exp_q.push_back({2'(w), m_err, m_err ? 8'h00 : unit_fn(m_x)});
                end
            end
        end
        if (|req_ready) begin
            last_rdy_cyc = cyc;
            last_rdy_vec = req_ready;
            rdy_cyc_q.push_back(cyc);
        end
        if (|rsp_valid) begin
            last_rsp_cyc  = cyc;
            last_rsp_data = rsp_data;
            last_rsp_err  = rsp_err;
            rsp_count++;
            own_q.push_back(oh_idx(rsp_valid));
            rsp_cyc_q.push_back(cyc);
        end
    end

    // ---------------- requester driver: drop (or renew) on req_ready ----------------
    logic [N-1:0] hold = '0;

    always begin
        @(posedge clk);
        #2;
        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                if (hold[i]) req_x[i*DW +: DW] = 8'($urandom);
                else         req_valid[i] = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic raise(input int i, input logic [DW-1:0] x);
        req_x[i*DW +: DW] = x;
        req_valid[i] = 1'b1;
    endtask

    task automatic wait_rsp(input string name);
        int start;
        int n;
        start = rsp_count;
        n = 0;
        while (rsp_count == start && n < 200) begin
            step(1);
            n++;
        end
        if (rsp_count == start) chk(name, 32'(0), 32'(1));
    endtask

    task automatic drain();
        int n;
        hold = '0;
        req_valid = '0;
        n = 0;
        step(1);
        while (busy && n < 100) begin
            step(1);
            n++;
        end
        if (busy) chk("drain_timeout", 32'(busy), 32'(0));
        step(2);
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
    endtask

    task automatic set_stub(input int mode, input int lat);
        stub_mode = mode;
        stub_lat  = lat;
    endtask

    // ---------------- test sequence ----------------
    int            cnt_before;
    int            own3_before;
    logic [DW-1:0] xa, xb;

    initial begin
        step(3);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        step(2);

        // 1: single request, nominal unit latency
        set_stub(0, softmax_pkg::EXP_NOMINAL_LAT);
        raise(0, 8'h38);
        wait_rsp("t1_wait");
        chk("t1_ready_vec", 32'(last_rdy_vec), 32'(4'b0001));
        chk("t1_latency", 32'(last_rsp_cyc - last_rdy_cyc), 32'(9));
        chk("t1_err", 32'(last_rsp_err), 32'(0));
        chk("t1_data", 32'(last_rsp_data), 32'(8'hD9));
        drain();

        // 2: all four held from a fresh pointer
        apply_reset();
        set_stub(0, 2);
        own_q.delete();
        rdy_cyc_q.delete();
        rsp_cyc_q.delete();
        hold = '1;
        for (int i = 0; i < N; i++) raise(i, 8'($urandom));
        for (int n = 0; n < 200 && own_q.size() < 5; n++) step(1);
        if (own_q.size() < 5) chk("t2_wait", 32'(own_q.size()), 32'(5));
        else begin
            chk("t2_order0", 32'(own_q[0]), 32'(0));
            chk("t2_order1", 32'(own_q[1]), 32'(1));
            chk("t2_order2", 32'(own_q[2]), 32'(2));
            chk("t2_order3", 32'(own_q[3]), 32'(3));
            chk("t2_order4", 32'(own_q[4]), 32'(0));
            for (int k = 0; k < 4; k++)
                chk("t2_gap", 32'(rdy_cyc_q[k+1] - rsp_cyc_q[k]), 32'(2));
        end
        drain();

        // 3: unit never acks, then a normal job
        set_stub(1, 0);
        raise(2, 8'h41);
        wait_rsp("t3_wait");
        chk("t3_latency", 32'(last_rsp_cyc - last_rdy_cyc), 32'(TO + 1));
        chk("t3_err", 32'(last_rsp_err), 32'(1));
        chk("t3_data", 32'(last_rsp_data), 32'(0));
        drain();
        set_stub(0, 3);
        xa = 8'h7C;
        raise(3, xa);
        wait_rsp("t3b_wait");
        chk("t3b_latency", 32'(last_rsp_cyc - last_rdy_cyc), 32'(5));
        chk("t3b_err", 32'(last_rsp_err), 32'(0));
        chk("t3b_data", 32'(last_rsp_data), 32'(8'h9D));
        drain();

        // 4: ack on the last allowed RUN cycle, then one cycle too late
        set_stub(0, TO - 1);
        raise(1, 8'h12);
        wait_rsp("t4_wait");
        chk("t4_latency", 32'(last_rsp_cyc - last_rdy_cyc), 32'(TO + 1));
        chk("t4_err", 32'(last_rsp_err), 32'(0));
        chk("t4_data", 32'(last_rsp_data), 32'(8'h7B));
        drain();
        set_stub(0, TO);
        raise(1, 8'h12);
        wait_rsp("t4b_wait");
        chk("t4b_err", 32'(last_rsp_err), 32'(1));
        chk("t4b_data", 32'(last_rsp_data), 32'(0));
        drain();

        // 5: reset in the middle of RUN
        set_stub(0, softmax_pkg::EXP_NOMINAL_LAT);
        cnt_before = rdy_cyc_q.size();
        raise(1, 8'h55);
        for (int n = 0; n < 20 && rdy_cyc_q.size() == cnt_before; n++) step(1);
        step(3);
        cnt_before = rsp_count;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_req_ready", 32'(req_ready), 32'(0));
        chk("t5_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("t5_exp_enable", 32'(exp_enable), 32'(0));
        chk("t5_busy", 32'(busy), 32'(0));
        chk("t5_exp_x", 32'(exp_x), 32'(0));
        chk("t5_rsp_data", 32'({rsp_err, rsp_data}), 32'(0));
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        step(20);
        chk("t5_no_rsp", 32'(rsp_count), 32'(cnt_before));
        raise(1, 8'h55);
        wait_rsp("t5b_wait");
        chk("t5b_latency", 32'(last_rsp_cyc - last_rdy_cyc), 32'(9));
        chk("t5b_data", 32'(last_rsp_data), 32'(unit_fn(8'h55)));
        drain();

        // 6: ack stuck high across jobs; withdrawn request gets nothing
        set_stub(2, 0);
        xa = 8'hA3;
        xb = 8'h0F;
        raise(1, xa);
        wait_rsp("t6a_wait");
        chk("t6a_latency", 32'(last_rsp_cyc - last_rdy_cyc), 32'(2));
        chk("t6a_data", 32'(last_rsp_data), 32'(8'h60));
        step(1);
        raise(2, xb);
        wait_rsp("t6b_wait");
        chk("t6b_latency", 32'(last_rsp_cyc - last_rdy_cyc), 32'(2));
        chk("t6b_data", 32'(last_rsp_data), 32'(8'hAA));
        drain();
        own3_before = 0;
        foreach (own_q[k]) if (own_q[k] == 3) own3_before++;
        cnt_before = rdy_cyc_q.size();
        raise(0, 8'h21);
        for (int n = 0; n < 20 && rdy_cyc_q.size() == cnt_before; n++) step(1);
        raise(3, 8'h99);
        step(1);
        req_valid[3] = 1'b0;
        step(10);
        begin
            int own3_now;
            own3_now = 0;
            foreach (own_q[k]) if (own_q[k] == 3) own3_now++;
            chk("t6_withdrawn", 32'(own3_now), 32'(own3_before));
        end
        drain();

        // randomized phases, each with one stub configuration
        for (int ph = 0; ph < 12; ph++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0)      set_stub(1, 0);
            else if (r == 1) set_stub(2, 0);
            else             set_stub(0, $urandom_range(0, 16));
            for (int c = 0; c < 120; c++) begin
                for (int i = 0; i < N; i++) begin
                    if (!req_valid[i] && $urandom_range(0, 3) == 0) raise(i, 8'($urandom));
                    else if (req_valid[i] && $urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
                end
                step(1);
            end
            drain();
        end
        chk("final_sb_empty", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
